intersection_traffic_model: RTL

//  Closed-loop road model for the traffic light controller: consumes the six lamp

---
 rtl/traffic_pkg.sv | 34 +++
 rtl/street_queue.sv | 64 ++++++
 rtl/intersection_traffic_model.sv | 100 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection road model: lamp encodings,
// monitor error codes, LFSR seeds and the per-street lamp sequence rule.
package traffic_pkg;

  // Lamp vectors are packed as {R, G, Y}
  typedef enum logic [2:0] {
    LAMP_R = 3'b100,
    LAMP_G = 3'b010,
    LAMP_Y = 3'b001
  } lamp_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_A_ONEHOT = 3'd1;
  localparam logic [2:0] ERR_B_ONEHOT = 3'd2;
  localparam logic [2:0] ERR_BOTH_GO  = 3'd3;
  localparam logic [2:0] ERR_SEQ      = 3'd4;

  localparam logic [4:0] LFSR_SEED_A = 5'b00000;
  localparam logic [4:0] LFSR_SEED_B = 5'b10101;

  // Legal per-street steps: G->G, G->Y, Y->R, R->R, R->G
  function automatic logic lamp_step_ok(input logic [2:0] prev, input logic [2:0] cur);
    logic ok;
    ok = 1'b0;
    case (prev)
      LAMP_G:  ok = (cur == LAMP_G) || (cur == LAMP_Y);
      LAMP_Y:  ok = (cur == LAMP_R);
      LAMP_R:  ok = (cur == LAMP_R) || (cur == LAMP_G);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/street_queue.sv
// One street of the road model: pseudo-random arrivals from a 5-bit XNOR
// LFSR, a green-time departure timer and a saturating vehicle queue with a
// sticky overflow flag.
module street_queue
  import traffic_pkg::*;
#(
  parameter int         QW         = 4,
  parameter int         ARR_BITS   = 2,
  parameter int         DEP_CYCLES = 3,
  parameter logic [4:0] SEED       = LFSR_SEED_A
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_green,
  output logic [QW-1:0] o_q,
  output logic          o_t,
  output logic          o_ov
);

  localparam int TW = (DEP_CYCLES > 1) ? $clog2(DEP_CYCLES) : 1;
  localparam logic [QW-1:0] QMAX = '1;

  logic [4:0]    r_lfsr;
  logic [TW-1:0] r_timer;
  logic [QW-1:0] r_q;
  logic          r_ov;
  logic          w_arr;
  logic          w_dep;

  // Arrival is decided from the LFSR value before this cycle's shift
  assign w_arr = &r_lfsr[ARR_BITS-1:0];
  assign w_dep = i_green && (r_timer == TW'(DEP_CYCLES - 1));

  // Free-running LFSR; all-zero is a normal state for the XNOR feedback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= SEED;
    else     r_lfsr <= {r_lfsr[3:0], ~(r_lfsr[2] ^ r_lfsr[4])};
  end

  // Departure timer counts continuous green and restarts on any non-green
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_timer <= '0;
    else if (!i_green || w_dep) r_timer <= '0;
    else                       r_timer <= r_timer + TW'(1);
  end

  // Queue: a simultaneous arrival and departure cancel, even at 0 or QMAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      r_ov <= 1'b0;
    end else if (w_arr && !w_dep) begin
      if (r_q == QMAX) r_ov <= 1'b1;
      else             r_q  <= r_q + QW'(1);
    end else if (w_dep && !w_arr && (r_q != '0)) begin
      r_q <= r_q - QW'(1);
    end
  end

  assign o_q  = r_q;
  assign o_t  = (r_q != '0);
  assign o_ov = r_ov;

endmodule

// File: rtl/intersection_traffic_model.sv
// Closed-loop road model for the traffic light controller. Takes the six
// lamp outputs and produces the TA/TB vehicle-present sensors plus queue
// lengths and overflow flags. Define LIGHT_CHECK_EN to build the sticky
// lamp-legality monitor; otherwise ERR and ERR_CODE are tied to zero.
module intersection_traffic_model
  import traffic_pkg::*;
#(
  parameter int QW         = 4,
  parameter int ARR_BITS   = 2,
  parameter int DEP_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RA,
  input  logic          GA,
  input  logic          YA,
  input  logic          RB,
  input  logic          GB,
  input  logic          YB,
  output logic          TA,
  output logic          TB,
  output logic [QW-1:0] QA,
  output logic [QW-1:0] QB,
  output logic          OVA,
  output logic          OVB,
  output logic          ERR,
  output logic [2:0]    ERR_CODE
);

  logic w_green_a;
  logic w_green_b;

  assign w_green_a = GA & ~RA & ~YA;
  assign w_green_b = GB & ~RB & ~YB;

  street_queue #(
    .QW(QW), .ARR_BITS(ARR_BITS), .DEP_CYCLES(DEP_CYCLES), .SEED(LFSR_SEED_A)
  ) u_street_a (
    .clk(clk), .rst(rst), .i_green(w_green_a), .o_q(QA), .o_t(TA), .o_ov(OVA)
  );

  street_queue #(
    .QW(QW), .ARR_BITS(ARR_BITS), .DEP_CYCLES(DEP_CYCLES), .SEED(LFSR_SEED_B)
  ) u_street_b (
    .clk(clk), .rst(rst), .i_green(w_green_b), .o_q(QB), .o_t(TB), .o_ov(OVB)
  );

`ifdef LIGHT_CHECK_EN
  logic [2:0] w_lamp_a;
  logic [2:0] w_lamp_b;
  logic [2:0] w_code;
  logic [2:0] r_prev_a;
  logic [2:0] r_prev_b;
  logic       r_prev_valid;
  logic       r_err;
  logic [2:0] r_err_code;

  assign w_lamp_a = {RA, GA, YA};
  assign w_lamp_b = {RB, GB, YB};

  // Highest-priority violation seen on the current lamps
  always_comb begin
    w_code = ERR_NONE;
    if (!$onehot(w_lamp_a))        w_code = ERR_A_ONEHOT;
    else if (!$onehot(w_lamp_b))   w_code = ERR_B_ONEHOT;
    else if (!RA && !RB)           w_code = ERR_BOTH_GO;
    else if (r_prev_valid &&
             (!lamp_step_ok(r_prev_a, w_lamp_a) || !lamp_step_ok(r_prev_b, w_lamp_b)))
                                   w_code = ERR_SEQ;
  end

  // Previous lamps are only meaningful once r_prev_valid is set
  always_ff @(posedge clk) begin
    r_prev_a <= w_lamp_a;
    r_prev_b <= w_lamp_b;
  end

  // Sticky error: the first violation wins and is never overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_prev_valid <= 1'b1;
      if (!r_err && (w_code != ERR_NONE)) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
    end
  end

  assign ERR      = r_err;
  assign ERR_CODE = r_err_code;
`else
  assign ERR      = 1'b0;
  assign ERR_CODE = ERR_NONE;
`endif

endmodule
